// File: rtl/cache_way_core.sv
// One way of a set-associative data cache.
// Holds the tag, valid, dirty and data arrays for one way. Hit detection and
// the word read are combinational. CPU writes on a hit and line fills from
// memory take effect on the rising clock edge.
module cache_way_core #(
  parameter int DATA = 32,
  parameter int ADDR = 32,
  parameter int OFST = 5,
  parameter int INDX = 9,
  localparam int BLCK = 8 << OFST
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            SYS,
  input  logic            dread,
  input  logic            dwrite,
  input  logic [1:0]      dwmode,
  input  logic            bread,
  input  logic            bwrite,
  input  logic [ADDR-1:0] address,
  input  logic [DATA-1:0] data_in,
  input  logic [BLCK-1:0] block_in,
  output logic [BLCK-1:0] block_out,
  output logic [DATA-1:0] data_out,
  output logic            hit
);

  localparam int TAGW  = ADDR - INDX - OFST;
  localparam int WSEL  = OFST - 2;
  localparam int DSH   = $clog2(DATA);
  localparam int LINES = 1 << INDX;

  // Merge right-aligned CPU write data into a stored word by write size.
  // Mode 11 leaves the word untouched.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] wr_data,
                                             input logic [1:0]  mode,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = old_w;
    case (mode)
      2'b00: res = wr_data;
      2'b01: begin
        if (lane[1]) begin
          res[31:16] = wr_data[15:0];
        end else begin
          res[15:0] = wr_data[15:0];
        end
      end
      2'b10: res[{lane, 3'b000} +: 8] = wr_data[7:0];
      default: res = old_w;
    endcase
    return res;
  endfunction

  // Storage arrays.
  logic [BLCK-1:0]  line_q [LINES];
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;

  // Address fields.
  logic [INDX-1:0]     idx_s;
  logic [TAGW-1:0]     tag_s;
  logic [WSEL-1:0]     wsel_s;
  logic [1:0]          lane_s;
  logic [WSEL+DSH-1:0] word_base_s;

  assign idx_s       = address[INDX+OFST-1:OFST];
  assign tag_s       = address[ADDR-1:INDX+OFST];
  assign wsel_s      = address[OFST-1:2];
  assign lane_s      = address[1:0];
  assign word_base_s = {wsel_s, {DSH{1'b0}}};

  // The read strobe has no effect on this way; the controller uses it.
  logic unused_s;
  assign unused_s = dread;

  // Combinational read path.
  assign block_out = line_q[idx_s];
  assign data_out  = block_out[word_base_s +: DATA];
  assign hit       = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

  // Write qualification. Reset and invalidate-all suppress both fills and
  // CPU writes, so a fill interrupted by either leaves the line invalid.
  // A fill in the same cycle as a CPU write drops the CPU write.
  logic fill_s;
  logic cpu_wr_s;
  logic line_we_s;

  assign fill_s    = bwrite && !RESET && !SYS;
  assign cpu_wr_s  = dwrite && hit && !bwrite && !RESET && !SYS && (dwmode != 2'b11);
  assign line_we_s = fill_s || cpu_wr_s;

  logic [DATA-1:0] new_word_s;
  logic [BLCK-1:0] merged_line_s;
  logic [BLCK-1:0] line_wdata_s;

  assign new_word_s = merge_word(data_out, data_in, dwmode, lane_s);

  // Build the line image written back on a CPU write hit.
  always_comb begin
    merged_line_s = block_out;
    merged_line_s[word_base_s +: DATA] = new_word_s;
  end

  assign line_wdata_s = fill_s ? block_in : merged_line_s;

  // Data and tag arrays: written by fills and CPU write hits, never reset.
  always_ff @(posedge CLK) begin
    if (line_we_s) begin
      line_q[idx_s] <= line_wdata_s;
    end
    if (fill_s) begin
      tag_q[idx_s] <= tag_s;
    end
  end

  // Next state of the indexed dirty bit. The write-back strobe wins over a
  // CPU write; an undriven (X/Z) bread falls through to the other branches.
  logic dirty_line_s;
  always_comb begin
    dirty_line_s = dirty_q[idx_s];
    if (bread) begin
      dirty_line_s = 1'b0;
    end else if (bwrite) begin
      dirty_line_s = 1'b0;
    end else if (cpu_wr_s) begin
      dirty_line_s = 1'b1;
    end else begin
      dirty_line_s = dirty_q[idx_s];
    end
  end

  // Next state of the valid and dirty vectors; invalidate-all clears both.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (SYS) begin
      valid_d = '0;
      dirty_d = '0;
    end else begin
      if (bwrite) begin
        valid_d[idx_s] = 1'b1;
      end else begin
        valid_d[idx_s] = valid_q[idx_s];
      end
      dirty_d[idx_s] = dirty_line_s;
    end
  end

  // Valid and dirty registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

endmodule

// File: tb/tb_cache_way_core.sv
// Self-checking bench for cache_way_core: directed scenarios followed by
// randomized traffic, checked through an expectation queue drained by a
// monitor on the falling clock edge.
module tb_cache_way_core;

  logic         CLK = 1'b0;
  logic         RESET, SYS, dread, dwrite, bread, bwrite;
  logic [1:0]   dwmode;
  logic [31:0]  address, data_in, data_out;
  logic [255:0] block_in, block_out;
  logic         hit;

  cache_way_core dut (
    .CLK(CLK), .RESET(RESET), .SYS(SYS), .dread(dread), .dwrite(dwrite),
    .dwmode(dwmode), .bread(bread), .bwrite(bwrite), .address(address),
    .data_in(data_in), .block_in(block_in), .block_out(block_out),
    .data_out(data_out), .hit(hit)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [95:0]  name;
    logic         exp_hit;
    bit           chk_data;
    logic [31:0]  exp_data;
    bit           chk_blk;
    logic [255:0] exp_blk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: what each line holds, from the cache rules.
  bit           m_valid [512];
  logic [17:0]  m_tag   [512];
  logic [255:0] m_line  [512];
  bit           m_known [512];

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[13:5]] && (m_tag[a[13:5]] == a[31:14]);
  endfunction

  task automatic push_exp(input logic [95:0] name, input logic h,
                          input bit cd, input logic [31:0] d,
                          input bit cb, input logic [255:0] b);
    exp_t e;
    e.name = name; e.exp_hit = h; e.chk_data = cd; e.exp_data = d;
    e.chk_blk = cb; e.exp_blk = b;
    exp_q.push_back(e);
  endtask

  task automatic push_model(input logic [95:0] name);
    logic [8:0]   i;
    logic [255:0] ln;
    int           w;
    i  = address[13:5];
    ln = m_line[i];
    w  = int'(address[4:2]);
    push_exp(name, m_hit(address), m_known[i], ln[w*32 +: 32], m_known[i], ln);
  endtask

  // Apply the effect of the inputs present at the last rising edge.
  task automatic commit();
    logic [8:0] i;
    bit         h;
    int         n, start, p;
    i = address[13:5];
    h = m_hit(address);
    if (RESET || SYS) begin
      for (int k = 0; k < 512; k++) m_valid[k] = 1'b0;
      if (bwrite || (dwrite && h)) m_known[i] = 1'b0;
    end else if (bwrite) begin
      m_line[i]  = block_in;
      m_tag[i]   = address[31:14];
      m_valid[i] = 1'b1;
      m_known[i] = 1'b1;
    end else if (dwrite && h && dwmode != 2'b11) begin
      case (dwmode)
        2'b00:   begin n = 4; start = 0; end
        2'b01:   begin n = 2; start = address[1] ? 2 : 0; end
        default: begin n = 1; start = int'(address[1:0]); end
      endcase
      for (int k = 0; k < n; k++) begin
        p = int'(address[4:2]) * 4 + start + k;
        m_line[i][p*8 +: 8] = data_in[k*8 +: 8];
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    commit();
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (hit !== mon_e.exp_hit) begin
        errors++;
        $display("FAIL %0s hit: got %b expected %b", mon_e.name, hit, mon_e.exp_hit);
      end
      if (mon_e.chk_data) begin
        checks++;
        if (data_out !== mon_e.exp_data) begin
          errors++;
          $display("FAIL %0s data_out: got %h expected %h", mon_e.name, data_out, mon_e.exp_data);
        end
      end
      if (mon_e.chk_blk) begin
        checks++;
        if (block_out !== mon_e.exp_blk) begin
          errors++;
          $display("FAIL %0s block_out: got %h expected %h", mon_e.name, block_out, mon_e.exp_blk);
        end
      end
    end
  end

  logic [255:0] blk5;
  logic [255:0] blk6;
  logic [17:0]  tags [2];
  logic [8:0]   idxs [4];
  int           r;

  initial begin
    RESET = 1'b1; SYS = 1'b0; dread = 1'b0; dwrite = 1'b0; bread = 1'b0;
    bwrite = 1'b0; dwmode = 2'b00; address = 32'h0; data_in = 32'h0; block_in = '0;
    for (int k = 0; k < 512; k++) begin
      m_valid[k] = 1'b0; m_known[k] = 1'b0; m_tag[k] = 18'h0; m_line[k] = '0;
    end
    step(); step();

    // 1: nothing valid after reset.
    RESET = 1'b0; address = 32'h0000_0040; dread = 1'b1;
    push_exp("t1_hit", 1'b0, 1'b0, 32'h0, 1'b0, '0);
    step();

    // 2: fill a line, then read words 0 and 7.
    dread = 1'b0; address = 32'h1234_5660;
    for (int k = 0; k < 8; k++) block_in[k*32 +: 32] = k;
    bwrite = 1'b1;
    push_exp("t2_prefill", 1'b0, 1'b0, 32'h0, 1'b0, '0);
    step();
    bwrite = 1'b0;
    push_exp("t2_word0", 1'b1, 1'b1, 32'h0000_0000, 1'b0, '0);
    step();
    address = 32'h1234_567C;
    push_exp("t2_word7", 1'b1, 1'b1, 32'h0000_0007, 1'b0, '0);
    step();

    // 3: byte then halfword writes into word 1.
    address = 32'h1234_5665; dwmode = 2'b10; data_in = 32'h0000_00AB; dwrite = 1'b1;
    push_exp("t3_bytewr", 1'b1, 1'b1, 32'h0000_0001, 1'b0, '0);
    step();
    dwrite = 1'b0; address = 32'h1234_5664;
    push_exp("t3_byterd", 1'b1, 1'b1, 32'h0000_AB01, 1'b0, '0);
    step();
    address = 32'h1234_5666; dwmode = 2'b01; data_in = 32'h0000_BEEF; dwrite = 1'b1;
    push_exp("t3_halfwr", 1'b1, 1'b1, 32'h0000_AB01, 1'b0, '0);
    step();
    dwrite = 1'b0; address = 32'h1234_5664;
    push_exp("t3_halfrd", 1'b1, 1'b1, 32'hBEEF_AB01, 1'b0, '0);
    step();

    // 4: tag mismatch misses and a write miss changes nothing.
    address = 32'h5234_5660; dwmode = 2'b00; data_in = 32'hFFFF_FFFF; dwrite = 1'b1;
    push_exp("t4_miss", 1'b0, 1'b0, 32'h0, 1'b0, '0);
    step();
    dwrite = 1'b0; address = 32'h1234_5660;
    push_exp("t4_orig", 1'b1, 1'b1, 32'h0000_0000, 1'b0, '0);
    step();

    // 5: fill beats a simultaneous write, then invalidate-all.
    for (int k = 0; k < 8; k++) blk5[k*32 +: 32] = 32'h100 + k;
    block_in = blk5; bwrite = 1'b1; dwrite = 1'b1; data_in = 32'hDEAD_BEEF;
    push_exp("t5_fillwr", 1'b1, 1'b1, 32'h0000_0000, 1'b0, '0);
    step();
    bwrite = 1'b0; dwrite = 1'b0;
    push_exp("t5_line", 1'b1, 1'b1, 32'h0000_0100, 1'b1, blk5);
    step();
    for (int k = 0; k < 8; k++) blk6[k*32 +: 32] = $urandom();
    address = 32'h0000_0040; block_in = blk6; bwrite = 1'b1;
    push_exp("t5_fill2", 1'b0, 1'b0, 32'h0, 1'b0, '0);
    step();
    bwrite = 1'b0;
    push_exp("t5_hit2", 1'b1, 1'b1, blk6[31:0], 1'b1, blk6);
    step();
    SYS = 1'b1;
    push_exp("t5_sysin", 1'b1, 1'b0, 32'h0, 1'b0, '0);
    step();
    SYS = 1'b0;
    push_exp("t5_sys40", 1'b0, 1'b0, 32'h0, 1'b0, '0);
    step();
    address = 32'h1234_5660;
    push_exp("t5_sys660", 1'b0, 1'b1, 32'h0000_0100, 1'b0, '0);
    step();

    // Randomized traffic over a few indices and two competing tags.
    tags[0] = 18'h048D1; tags[1] = 18'h148D1;
    idxs[0] = 9'h0B3; idxs[1] = 9'h002; idxs[2] = 9'h000; idxs[3] = 9'h1FF;
    for (int c = 0; c < 1500; c++) begin
      r       = int'($urandom_range(99));
      address = {tags[$urandom_range(1)], idxs[$urandom_range(3)],
                 3'($urandom_range(7)), 2'($urandom_range(3))};
      RESET   = (r < 1);
      SYS     = (r >= 1 && r < 3);
      bwrite  = (r >= 3 && r < 25);
      dwrite  = ($urandom_range(99) < 45);
      dwmode  = 2'($urandom_range(3));
      data_in = $urandom();
      bread   = ($urandom_range(9) == 0);
      dread   = 1'($urandom_range(1));
      for (int k = 0; k < 8; k++) block_in[k*32 +: 32] = $urandom();
      push_model("rand");
      step();
    end

    RESET = 1'b0; SYS = 1'b0; bwrite = 1'b0; dwrite = 1'b0; bread = 1'b0;
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
